// File: rtl/t06_uart_tx.sv
// Serial transmitter paced by a one-cycle baud_tick strobe from the clock-enable divider.
// Sends start bit, DATA_BITS data bits LSB first, then STOP_BITS stop bits, one tick period each.
module t06_uart_tx #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic                 tx_o,
   output logic                 busy_o,
   output logic                 done_o
);

   // Handshake: a word is accepted on any clock edge where valid_i and ready_o are both high;
   // ready_o stays low for the whole frame and rises on the edge that pulses done_o.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      tx_d       = tx_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            // A tick coinciding with the accept is deliberately not used for the start bit.
            if (valid_i) begin
               shift_d = data_i;
               state_d = ARM;
            end
         end
         ARM: begin
            if (baud_tick) begin
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (baud_tick) begin
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = 4'd0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                  tx_d       = 1'b1;
                  stop_cnt_d = 1'b0;
                  state_d    = STOP;
               end else begin
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         STOP: begin
            if (baud_tick) begin
               if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= 4'd0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

   assign ready_o = (state_q == IDLE);
   assign busy_o  = (state_q != IDLE);
   assign tx_o    = tx_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_t06_uart_tx.sv
// Bench for t06_uart_tx: two instances (8N1 and 7 data / 2 stop) checked every cycle against a
// tick-counting frame model, plus directed line-level sequences.
module tb_t06_uart_tx;

   localparam logic L = 1'b0;
   localparam logic H = 1'b1;

   // ---------------- clock / reset ----------------
   logic clk  = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   logic       baud_tick = 1'b0;
   int         div_max   = 3;
   int         div_cnt   = 0;
   logic [1:0] valid_v   = 2'b00;
   logic [8:0] data_v [2];
   wire  [1:0] ready_v, busy_v, tx_v, done_v;

   int n_cmp = 0;
   int n_err = 0;

   t06_uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) u_dut8 (
      .clk(clk), .nrst(nrst), .baud_tick(baud_tick), .data_i(data_v[0][7:0]),
      .valid_i(valid_v[0]), .ready_o(ready_v[0]), .tx_o(tx_v[0]), .busy_o(busy_v[0]),
      .done_o(done_v[0]));

   t06_uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) u_dut7 (
      .clk(clk), .nrst(nrst), .baud_tick(baud_tick), .data_i(data_v[1][6:0]),
      .valid_i(valid_v[1]), .ready_o(ready_v[1]), .tx_o(tx_v[1]), .busy_o(busy_v[1]),
      .done_o(done_v[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int nbits(input int id);
      return (id == 0) ? 8 : 7;
   endfunction

   function automatic int sbits(input int id);
      return (id == 0) ? 1 : 2;
   endfunction

   // ---------------- reference model ----------------
   // A frame is a list of line levels {0, data LSB first, 1 x stop}; the k-th tick after the
   // accept puts level k-1 on the line, and the tick after the last level ends the frame.
   logic m_busy [2] = '{1'b0, 1'b0};
   int   m_k    [2] = '{0, 0};
   int   m_len  [2] = '{0, 0};
   logic m_lev  [2][12];
   logic m_tx   [2] = '{1'b1, 1'b1};
   logic m_done [2] = '{1'b0, 1'b0};

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int id = 0; id < 2; id++) begin
            m_busy[id] <= 1'b0;
            m_k[id]    <= 0;
            m_tx[id]   <= 1'b1;
            m_done[id] <= 1'b0;
         end
      end else begin
         for (int id = 0; id < 2; id++) begin
            m_done[id] <= 1'b0;
            if (!m_busy[id]) begin
               if (valid_v[id]) begin
                  m_busy[id] <= 1'b1;
                  m_k[id]    <= 0;
                  m_len[id]  <= 1 + nbits(id) + sbits(id);
                  for (int j = 0; j < 12; j++)
                     m_lev[id][j] <= (j == 0) ? 1'b0 :
                                     (j <= nbits(id)) ? data_v[id][j-1] : 1'b1;
               end
            end else if (baud_tick) begin
               m_k[id] <= m_k[id] + 1;
               if (m_k[id] < m_len[id]) begin
                  m_tx[id] <= m_lev[id][m_k[id]];
               end else begin
                  m_done[id] <= 1'b1;
                  m_busy[id] <= 1'b0;
                  m_tx[id]   <= 1'b1;
               end
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      for (int id = 0; id < 2; id++) begin
         check($sformatf("tx%0d", id),    tx_v[id],    m_tx[id]);
         check($sformatf("ready%0d", id), ready_v[id], !m_busy[id]);
         check($sformatf("busy%0d", id),  busy_v[id],  m_busy[id]);
         check($sformatf("done%0d", id),  done_v[id],  m_done[id]);
      end
   end

   // Line level after every tick edge, and done pulses, sampled just after the rising edge.
   logic line_q0 [$];
   logic line_q1 [$];
   logic [0:0] exp_q [$];
   int   seen_done [2] = '{0, 0};

   always @(posedge clk) begin
      logic tk;
      tk = baud_tick;
      #1;
      for (int id = 0; id < 2; id++)
         if (done_v[id] === 1'b1) seen_done[id]++;
      if (tk) begin
         line_q0.push_back(tx_v[0]);
         line_q1.push_back(tx_v[1]);
      end
   end

   task automatic check_line(input int id, input string tag);
      logic got;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (id == 0) got = (i < line_q0.size()) ? line_q0[i] : 1'bx;
         else         got = (i < line_q1.size()) ? line_q1[i] : 1'bx;
         check($sformatf("%s_p%0d", tag, i), got, exp_q[i]);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic next_cycle();
      @(negedge clk);
      if (div_cnt >= div_max) div_cnt = 0;
      else                    div_cnt++;
      baud_tick = (div_cnt == div_max);
   endtask

   task automatic send(input int id, input logic [8:0] d, input bit align, input bit hold);
      int g = 0;
      do begin
         next_cycle();
         g++;
      end while (!(ready_v[id] && (!align || baud_tick)) && g < 400);
      check("send_wait", (g < 400), 1);
      data_v[id]  = d;
      valid_v[id] = 1'b1;
      next_cycle();
      if (!hold) valid_v[id] = 1'b0;
      data_v[id] = 9'($urandom);
      if (id == 0) line_q0.delete();
      else         line_q1.delete();
   endtask

   task automatic wait_done(input int id, input bit scramble);
      int g = 0;
      while (!ready_v[id] && g < 800) begin
         next_cycle();
         if (scramble) data_v[id] = 9'($urandom);
         g++;
      end
      check("frame_wait", (g < 800), 1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int d0;
      int g;
      data_v[0] = '0;
      data_v[1] = '0;
      repeat (3) next_cycle();
      check("rst_tx", tx_v[0], 1);
      check("rst_ready", ready_v[0], 1);
      check("rst_busy", busy_v[0], 0);
      nrst = 1'b1;
      repeat (2) next_cycle();

      // single 0xA5 frame, tick every 4 clocks
      div_max = 3;
      d0 = seen_done[0];
      send(0, 9'h0A5, 1'b0, 1'b0);
      wait_done(0, 1'b0);
      exp_q = '{L, H, L, H, L, L, H, L, H, H};
      check_line(0, "a5");
      check("a5_done_cnt", seen_done[0] - d0, 1);

      // valid coinciding with a tick in IDLE
      repeat (3) next_cycle();
      send(0, 9'h000, 1'b1, 1'b0);
      wait_done(0, 1'b0);
      exp_q = '{L, L, L, L, L, L, L, L, L, H};
      check_line(0, "coinc");

      // back-to-back with valid held high
      d0 = seen_done[0];
      send(0, 9'h0FF, 1'b0, 1'b1);
      send(0, 9'h001, 1'b0, 1'b0);
      wait_done(0, 1'b0);
      exp_q = '{L, H, L, L, L, L, L, L, L, H};
      check_line(0, "b2b");
      check("b2b_done_cnt", seen_done[0] - d0, 2);

      // 7 data bits, 2 stop bits
      d0 = seen_done[1];
      send(1, 9'h055, 1'b0, 1'b0);
      wait_done(1, 1'b0);
      exp_q = '{L, H, L, H, L, H, L, H, H, H};
      check_line(1, "p72");
      check("p72_done_cnt", seen_done[1] - d0, 1);

      // data_i scrambled every cycle after the accept
      send(0, 9'h03C, 1'b0, 1'b0);
      wait_done(0, 1'b1);
      exp_q = '{L, L, L, H, H, H, H, L, L, H};
      check_line(0, "capture");

      // asynchronous reset in the middle of the data bits
      send(0, 9'h000, 1'b0, 1'b0);
      g = 0;
      while (m_k[0] != 4 && g < 200) begin
         next_cycle();
         g++;
      end
      check("mid_wait", (g < 200), 1);
      check("mid_tx_low", tx_v[0], 0);
      d0 = seen_done[0];
      #2 nrst = 1'b0;
      #1;
      check("arst_tx", tx_v[0], 1);
      check("arst_ready", ready_v[0], 1);
      check("arst_busy", busy_v[0], 0);
      repeat (3) next_cycle();
      nrst = 1'b1;
      repeat (20) next_cycle();
      check("arst_no_done", seen_done[0] - d0, 0);

      // randomized frames, tick periods 2..6 clocks
      for (int r = 0; r < 60; r++) begin
         int id;
         id = $urandom_range(0, 1);
         div_max = $urandom_range(1, 5);
         repeat ($urandom_range(0, 6)) next_cycle();
         if ($urandom_range(0, 2) == 0) begin
            send(id, 9'($urandom), 1'b0, 1'b1);
            send(id, 9'($urandom), 1'b0, 1'b0);
         end else begin
            send(id, 9'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
         end
         wait_done(id, ($urandom_range(0, 1) == 1));
      end

      valid_v = 2'b00;
      repeat (10) next_cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
